// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular FIFO of {pc, instr, fault}
// entries with a valid/ready head and a full flush on redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     redir_i,
  input  logic                     f_valid_i,
  input  logic [XLEN-1:0]          f_pc_i,
  input  logic [XLEN-1:0]          f_instr_i,
  input  logic                     f_fault_i,
  output logic                     f_ready_o,
  output logic                     d_valid_o,
  output logic [XLEN-1:0]          d_pc_o,
  output logic [XLEN-1:0]          d_instr_o,
  output logic                     d_fault_o,
  input  logic                     d_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            enq;
  logic            deq;

  // Ready looks only at registered occupancy, so a full queue refuses a write
  // even when decode drains the head in the same cycle.
  assign f_ready_o = (count != FULL);
  assign d_valid_o = (count != '0) && !redir_i;
  assign enq       = f_valid_i && f_ready_o;
  assign deq       = d_valid_o && d_ready_i;
  assign count_o   = count;

  assign head      = mem[rd_ptr];
  assign d_pc_o    = d_valid_o ? head.pc    : '0;
  assign d_instr_o = d_valid_o ? head.instr : '0;
  assign d_fault_o = d_valid_o && head.fault;

  // NOTE: storage carries no reset; an empty queue masks whatever the array holds.
  always_ff @(posedge clk_i) begin
    if (enq && !redir_i) begin
      mem[wr_ptr] <= '{pc: f_pc_i, instr: f_instr_i, fault: f_fault_i};
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redir_i) begin
      // Flush beats both enqueue and dequeue: the incoming entry is wrong-path.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= FULL);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(enq && count == FULL));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(deq && count == '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, XLEN=32).
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            redir_i = 1'b0;
  logic            f_valid_i = 1'b0;
  logic [XLEN-1:0] f_pc_i = '0;
  logic [XLEN-1:0] f_instr_i = '0;
  logic            f_fault_i = 1'b0;
  logic            f_ready_o;
  logic            d_valid_o;
  logic [XLEN-1:0] d_pc_o;
  logic [XLEN-1:0] d_instr_o;
  logic            d_fault_o;
  logic            d_ready_i = 1'b0;
  logic [$clog2(DEPTH):0] count_o;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .redir_i   (redir_i),
    .f_valid_i (f_valid_i),
    .f_pc_i    (f_pc_i),
    .f_instr_i (f_instr_i),
    .f_fault_i (f_fault_i),
    .f_ready_o (f_ready_o),
    .d_valid_o (d_valid_o),
    .d_pc_o    (d_pc_o),
    .d_instr_o (d_instr_o),
    .d_fault_o (d_fault_o),
    .d_ready_i (d_ready_i),
    .count_o   (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic v, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] instr, input logic fault);
    f_valid_i = v;
    f_pc_i    = pc;
    f_instr_i = instr;
    f_fault_i = fault;
  endtask

  initial begin
    logic [XLEN-1:0] exp_seq [6];
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};

    // Reset state
    tick();
    tick();
    check("rst_valid", 64'(d_valid_o), 64'd0);
    check("rst_ready", 64'(f_ready_o), 64'd1);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_pc", 64'(d_pc_o), 64'd0);
    check("rst_instr", 64'(d_instr_o), 64'd0);
    check("rst_fault", 64'(d_fault_o), 64'd0);
    rst_ni = 1'b1;

    // Single entry, held until consumed
    present(1'b1, 32'h0, 32'h13, 1'b0);
    tick();
    present(1'b0, '0, '0, 1'b0);
    #1;
    check("single_valid", 64'(d_valid_o), 64'd1);
    check("single_pc", 64'(d_pc_o), 64'h0);
    check("single_instr", 64'(d_instr_o), 64'h13);
    check("single_count", 64'(count_o), 64'd1);
    tick();
    check("single_hold_valid", 64'(d_valid_o), 64'd1);
    check("single_hold_instr", 64'(d_instr_o), 64'h13);
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;
    check("single_drain_count", 64'(count_o), 64'd0);
    check("single_drain_valid", 64'(d_valid_o), 64'd0);

    // Fill to DEPTH, then drain while enqueueing across the pointer wrap
    for (int i = 0; i < 4; i++) begin
      present(1'b1, 32'(4 * i), 32'(32'h100 + i), 1'b0);
      tick();
    end
    present(1'b0, '0, '0, 1'b0);
    #1;
    check("full_count", 64'(count_o), 64'd4);
    check("full_ready", 64'(f_ready_o), 64'd0);
    d_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 2)       present(1'b1, 32'h10, 32'h110, 1'b0);
      else if (k == 2) present(1'b1, 32'h14, 32'h114, 1'b0);
      else             present(1'b0, '0, '0, 1'b0);
      #1;
      if (k == 0) check("wrap_full_ready", 64'(f_ready_o), 64'd0);
      if (k == 1) check("wrap_no_enq_when_full", 64'(count_o), 64'd3);
      check($sformatf("wrap_valid_%0d", k), 64'(d_valid_o), 64'd1);
      check($sformatf("wrap_pc_%0d", k), 64'(d_pc_o), 64'(exp_seq[k]));
      tick();
    end
    d_ready_i = 1'b0;
    check("wrap_empty_count", 64'(count_o), 64'd0);
    check("wrap_empty_valid", 64'(d_valid_o), 64'd0);

    // Streaming: one entry per cycle, occupancy pinned at 1
    d_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      present(1'b1, 32'(32'h1000 + 4 * i), 32'(32'h2000 + i), 1'b0);
      #1;
      if (i > 0) begin
        check($sformatf("stream_valid_%0d", i), 64'(d_valid_o), 64'd1);
        check($sformatf("stream_pc_%0d", i), 64'(d_pc_o), 64'(32'h1000 + 4 * (i - 1)));
        check($sformatf("stream_count_%0d", i), 64'(count_o), 64'd1);
      end
      tick();
    end
    present(1'b0, '0, '0, 1'b0);
    #1;
    check("stream_last_pc", 64'(d_pc_o), 64'(32'h1000 + 4 * 19));
    tick();
    d_ready_i = 1'b0;
    check("stream_empty", 64'(count_o), 64'd0);

    // Flush colliding with enqueue and dequeue
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 32'(32'h20 + 4 * i), 32'h13, 1'b0);
      tick();
    end
    check("flush_pre_count", 64'(count_o), 64'd3);
    redir_i = 1'b1;
    d_ready_i = 1'b1;
    present(1'b1, 32'h40, 32'h13, 1'b0);
    #1;
    check("flush_valid_low", 64'(d_valid_o), 64'd0);
    check("flush_pc_masked", 64'(d_pc_o), 64'd0);
    tick();
    redir_i = 1'b0;
    d_ready_i = 1'b0;
    present(1'b1, 32'h200, 32'h6f, 1'b0);
    #1;
    check("flush_post_count", 64'(count_o), 64'd0);
    check("flush_post_valid", 64'(d_valid_o), 64'd0);
    tick();
    present(1'b0, '0, '0, 1'b0);
    #1;
    check("flush_next_valid", 64'(d_valid_o), 64'd1);
    check("flush_next_pc", 64'(d_pc_o), 64'h200);
    check("flush_next_count", 64'(count_o), 64'd1);
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;
    check("flush_drained", 64'(count_o), 64'd0);

    // Fault flag travels with its entry
    present(1'b1, 32'h8000_0000, 32'h0, 1'b1);
    tick();
    present(1'b1, 32'h8000_0004, 32'h13, 1'b0);
    tick();
    present(1'b0, '0, '0, 1'b0);
    #1;
    check("fault_set", 64'(d_fault_o), 64'd1);
    check("fault_pc", 64'(d_pc_o), 64'h8000_0000);
    d_ready_i = 1'b1;
    tick();
    check("fault_clear", 64'(d_fault_o), 64'd0);
    check("fault_next_pc", 64'(d_pc_o), 64'h8000_0004);
    tick();
    d_ready_i = 1'b0;
    check("fault_drained", 64'(count_o), 64'd0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      present(1'b1, 32'(32'h300 + 4 * i), 32'h13, 1'b0);
      tick();
    end
    present(1'b0, '0, '0, 1'b0);
    check("arst_pre_count", 64'(count_o), 64'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_valid", 64'(d_valid_o), 64'd0);
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_ready", 64'(f_ready_o), 64'd1);
    check("arst_pc", 64'(d_pc_o), 64'd0);
    #1;
    rst_ni = 1'b1;
    tick();
    check("arst_after_count", 64'(count_o), 64'd0);
    check("arst_after_valid", 64'(d_valid_o), 64'd0);
    present(1'b1, 32'h400, 32'h13, 1'b0);
    tick();
    present(1'b0, '0, '0, 1'b0);
    #1;
    check("arst_new_pc", 64'(d_pc_o), 64'h400);
    check("arst_new_count", 64'(count_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
